width_unpacker: RTL and testbench



---
 rtl/width_unpacker.sv | 82 ++++++++
 tb/tb_width_unpacker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/width_unpacker.sv
// Splits M-bit words from a valid/ready input into R = M/N consecutive N-bit
// slices on a valid/ready output, MSB slice first, through a 2-entry word buffer.
`timescale 1ns/1ps
module width_unpacker #(
  parameter int N = 8,
  parameter int M = 32,
  localparam int R = M / N,
  localparam int CNT_WIDTH = $clog2(R)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [M-1:0] din,
  output logic         rdy_o,
  output logic         vld_o,
  output logic [N-1:0] dout,
  input  logic         rdy_i,
  output logic [1:0]   level
);

  if ((M % N != 0) || (M < 2 * N)) begin : g_bad_params
    $error("width_unpacker: M must be a multiple of N and at least 2*N");
  end

  localparam logic [CNT_WIDTH-1:0] LAST_SIDX = CNT_WIDTH'(R - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready on that
  // side; a source holds its word/slice stable until it is accepted.
  logic [M-1:0]         r_buf [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic [CNT_WIDTH-1:0] r_sidx;

  logic         w_push;
  logic         w_pop;
  logic         w_retire;
  logic [M-1:0] w_head;

  assign rdy_o    = !rst && (r_count != 2'd2);
  assign vld_o    = (r_count != 2'd0);
  assign level    = r_count;
  assign w_push   = vld_i && rdy_o;
  assign w_pop    = vld_o && rdy_i;
  assign w_retire = w_pop && (r_sidx == LAST_SIDX);
  assign w_head   = r_buf[r_rd_ptr];

  always_comb begin
    dout = '0;
    if (vld_o) dout = w_head[M-1-int'(r_sidx)*N -: N];
  end

  // Buffer contents need no reset: a slot is only read once count covers it.
  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_sidx   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop) begin
        if (w_retire) begin
          r_sidx   <= '0;
          r_rd_ptr <= ~r_rd_ptr;
        end else begin
          r_sidx <= r_sidx + CNT_WIDTH'(1);
        end
      end
      case ({w_push, w_retire})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_width_unpacker.sv
// Directed bench for width_unpacker (8/32 and 16/32 instances) with a
// slice-level expected queue for streamed and randomised traffic.
`timescale 1ns/1ps
module tb_width_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_i;
  logic [31:0] din;
  logic        rdy_o;
  logic        vld_o;
  logic [7:0]  dout;
  logic        rdy_i;
  logic [1:0]  level;

  logic        w16_vld_i;
  logic [31:0] w16_din;
  logic        w16_rdy_o;
  logic        w16_vld_o;
  logic [15:0] w16_dout;
  logic        w16_rdy_i;
  logic [1:0]  w16_level;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] src_q[$];
  logic        hold_prev;
  logic [7:0]  hold_dout;

  always #5 clk = ~clk;

  width_unpacker #(.N(8), .M(32)) u_dut (
    .clk(clk), .rst(rst), .vld_i(vld_i), .din(din), .rdy_o(rdy_o),
    .vld_o(vld_o), .dout(dout), .rdy_i(rdy_i), .level(level)
  );

  width_unpacker #(.N(16), .M(32)) u_dut16 (
    .clk(clk), .rst(rst), .vld_i(w16_vld_i), .din(w16_din), .rdy_o(w16_rdy_o),
    .vld_o(w16_vld_o), .dout(w16_dout), .rdy_i(w16_rdy_i), .level(w16_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_slices(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[31-8*k -: 8]);
  endtask

  // Source drives words from src_q; each accepted output beat is matched
  // against exp_q, and a stalled beat must hold until taken.
  task automatic run(input int budget, input bit rand_mode);
    int n;
    bit hs;
    bit done;
    n = 0;
    done = 1'b0;
    hold_prev = 1'b0;
    while (!done) begin
      rdy_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (src_q.size() == 0) vld_i = 1'b0;
      else if (!vld_i) vld_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      din = (src_q.size() != 0) ? src_q[0] : 32'h0;
      if (hold_prev) begin
        chk("hold_vld", 32'(vld_o), 32'd1);
        chk("hold_dout", 32'(dout), 32'(hold_dout));
      end
      if (vld_o && rdy_i) begin
        if (exp_q.size() == 0) chk("unexpected_beat_queue", 32'(exp_q.size()), 32'd1);
        else chk("stream_beat", 32'(dout), 32'(exp_q.pop_front()));
      end
      hold_prev = vld_o && !rdy_i;
      hold_dout = dout;
      hs = vld_i && rdy_o;
      if (hs) push_slices(din);
      tick();
      if (hs) void'(src_q.pop_front());
      n++;
      if (src_q.size() == 0 && exp_q.size() == 0 && !vld_o) begin
        done = 1'b1;
      end else if (n >= budget) begin
        chk("run_timeout_pending", 32'(exp_q.size() + src_q.size() + int'(vld_o)), 32'd0);
        done = 1'b1;
      end
    end
    vld_i = 1'b0;
  endtask

  initial begin
    logic [7:0]  b2 [8];
    logic [31:0] w;
    b2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    rst = 1'b1; vld_i = 1'b0; din = '0; rdy_i = 1'b0;
    w16_vld_i = 1'b0; w16_din = '0; w16_rdy_i = 1'b0;
    hold_prev = 1'b0; hold_dout = '0;
    tick();
    tick();
    chk("reset_vld_o", 32'(vld_o), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_rdy_o", 32'(rdy_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_rdy_o", 32'(rdy_o), 32'd1);

    // Single word, no same-cycle bypass.
    vld_i = 1'b1; din = 32'hAABBCCDD; rdy_i = 1'b1;
    #1;
    chk("no_bypass_vld_o", 32'(vld_o), 32'd0);
    tick();
    vld_i = 1'b0;
    chk("single_level", 32'(level), 32'd1);
    w = 32'hAABBCCDD;
    for (int k = 0; k < 4; k++) begin
      chk("single_vld_o", 32'(vld_o), 32'd1);
      chk("single_dout", 32'(dout), 32'(w[31-8*k -: 8]));
      tick();
    end
    chk("single_end_vld_o", 32'(vld_o), 32'd0);
    chk("single_end_dout", 32'(dout), 32'd0);
    chk("single_end_level", 32'(level), 32'd0);

    // Back-to-back words with no gap.
    vld_i = 1'b1; din = 32'h01020304;
    tick();
    chk("b2b_dout0", 32'(dout), 32'(b2[0]));
    din = 32'h05060708;
    tick();
    vld_i = 1'b0;
    chk("b2b_level", 32'(level), 32'd2);
    chk("b2b_rdy_o_full", 32'(rdy_o), 32'd0);
    for (int k = 1; k < 8; k++) begin
      chk("b2b_vld_o", 32'(vld_o), 32'd1);
      chk("b2b_dout", 32'(dout), 32'(b2[k]));
      tick();
    end
    chk("b2b_end_vld_o", 32'(vld_o), 32'd0);

    // Backpressure: two words buffered, third held by the source.
    rdy_i = 1'b0; vld_i = 1'b1; din = 32'h11223344;
    tick();
    din = 32'h55667788;
    tick();
    din = 32'h99AABBCC;
    chk("bp_level", 32'(level), 32'd2);
    chk("bp_rdy_o", 32'(rdy_o), 32'd0);
    chk("bp_dout", 32'(dout), 32'h11);
    tick();
    chk("bp_hold_level", 32'(level), 32'd2);
    chk("bp_hold_dout", 32'(dout), 32'h11);
    chk("bp_hold_vld_o", 32'(vld_o), 32'd1);
    push_slices(32'h11223344);
    push_slices(32'h55667788);
    src_q.push_back(32'h99AABBCC);
    run(100, 1'b0);
    chk("bp_end_level", 32'(level), 32'd0);

    // Reset in the middle of a word.
    vld_i = 1'b1; din = 32'hDEADBEEF; rdy_i = 1'b1;
    tick();
    vld_i = 1'b0;
    chk("mid_dout_de", 32'(dout), 32'hDE);
    tick();
    chk("mid_dout_ad", 32'(dout), 32'hAD);
    tick();
    rst = 1'b1; rdy_i = 1'b0;
    #1;
    chk("mid_rst_rdy_o_comb", 32'(rdy_o), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("mid_rst_vld_o", 32'(vld_o), 32'd0);
      chk("mid_rst_rdy_o", 32'(rdy_o), 32'd0);
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_dout", 32'(dout), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("mid_post_rdy_o", 32'(rdy_o), 32'd1);
    vld_i = 1'b1; din = 32'hCAFEF00D; rdy_i = 1'b1;
    tick();
    vld_i = 1'b0;
    w = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) begin
      chk("mid_next_vld_o", 32'(vld_o), 32'd1);
      chk("mid_next_dout", 32'(dout), 32'(w[31-8*k -: 8]));
      tick();
    end
    chk("mid_next_end_vld_o", 32'(vld_o), 32'd0);

    // 16-bit slices from 32-bit words.
    w16_vld_i = 1'b1; w16_din = 32'h12345678; w16_rdy_i = 1'b1;
    tick();
    w16_vld_i = 1'b0;
    chk("n16_vld_o0", 32'(w16_vld_o), 32'd1);
    chk("n16_dout0", 32'(w16_dout), 32'h1234);
    tick();
    chk("n16_dout1", 32'(w16_dout), 32'h5678);
    tick();
    chk("n16_end_vld_o", 32'(w16_vld_o), 32'd0);
    chk("n16_end_level", 32'(w16_level), 32'd0);

    // Random valid/ready over many words.
    for (int k = 0; k < 1000; k++) src_q.push_back($urandom);
    run(30000, 1'b1);
    chk("rand_end_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
